// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// No logic of its own; holds state encodings, owner ids and a small helper.
// Imported by mem_port_arbiter and rr_arb2.
package mem_arb_pkg;

    // Arbiter sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Requester identities; also used as the round-robin grant id
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    // The requester that did not hold the last grant
    function automatic logic other_owner(input logic owner);
        return (owner == OWN_CPU) ? OWN_EXT : OWN_CPU;
    endfunction

    // Counter width able to hold MEM_LAT-1 (at least one bit)
    function automatic int cnt_width(input int mem_lat);
        return (mem_lat < 2) ? 1 : $clog2(mem_lat + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: grants the single requester, or the one that did not win last time.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed and updates last_grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Pick a winner: lone requester wins outright, a conflict goes to the non-last owner
    always_comb begin
        grant_valid = |req;
        grant_id    = OWN_CPU;
        if (req == 2'b11) begin
            grant_id = other_owner(last_grant);
        end else if (req[OWN_EXT]) begin
            grant_id = OWN_EXT;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the core and an external loader/debug port.
// Latency: request sampled in IDLE at edge N -> strobes for cycles N..N+MEM_LAT-1, ack in cycle N+MEM_LAT.
// Backpressure: the non-owner simply waits (cpu_stall held); round-robin bounds the wait to one foreign access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,

    input  logic          ext_rd,
    input  logic          ext_wr,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_ack,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW       = cnt_width(MEM_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          is_wr;

    logic          req_cpu;
    logic          req_ext;
    logic          grant_valid;
    logic          grant_id;

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_wr;

    assign req_cpu = cpu_rd | cpu_wr;
    assign req_ext = ext_rd | ext_wr;

    // Low on the ack cycle so the core's state register advances exactly once
    assign cpu_stall = req_cpu & ~cpu_ack;

    rr_arb2 u_rr_arb2 (
        .req         ({req_ext, req_cpu}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Operand mux for the requester about to be granted; write wins over read
    always_comb begin
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        sel_wr    = cpu_wr;
        if (grant_id == OWN_EXT) begin
            sel_addr  = ext_addr;
            sel_wdata = ext_wdata;
            sel_wr    = ext_wr;
        end
    end

    // Access sequencer: grant in IDLE, hold strobe MEM_LAT cycles, one-cycle ack in RESP
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= OWN_EXT;
            cnt        <= '0;
            owner      <= OWN_CPU;
            is_wr      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            cpu_ack    <= 1'b0;
            ext_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        // mem_addr/mem_wdata double as the operand latches for the access
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        is_wr      <= sel_wr;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_read   <= ~sel_wr;
                        mem_write  <= sel_wr;
                        cnt        <= CNT_LOAD;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // Last strobe cycle: read data is valid now
                        if (!is_wr) begin
                            if (owner == OWN_CPU) begin
                                cpu_rdata <= mem_rdata;
                            end else begin
                                ext_rdata <= mem_rdata;
                            end
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cpu_ack   <= (owner == OWN_CPU);
                        ext_ack   <= (owner == OWN_EXT);
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    cpu_ack <= 1'b0;
                    ext_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    cpu_ack   <= 1'b0;
                    ext_ack   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
